// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell and a carry flop process WIDTH bits,
// streaming each sum bit and presenting the parallel sum/cout with a one-cycle done pulse.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             bit_out,
    output logic             bit_valid
);

    localparam int unsigned IdxW = $clog2(WIDTH);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAdd,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q, bit_valid_d;

    logic fa_sum;
    logic fa_carry;
    logic accept;

    assign fa_sum   = a_q[0] ^ b_q[0] ^ carry_q;
    assign fa_carry = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    // A start is only honoured when not busy, which includes the done cycle.
    assign accept   = start && (state_q != StAdd);

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StAdd;
            end
            StAdd: begin
                a_d         = a_q >> 1;
                b_d         = b_q >> 1;
                carry_d     = fa_carry;
                sum_d       = {fa_sum, sum_q[WIDTH-1:1]};
                bit_out_d   = fa_sum;
                bit_valid_d = 1'b1;
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                    cout_d  = fa_carry;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                state_d = start ? StAdd : StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            idx_d   = '0;
            sum_d   = '0;
            cout_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
        end
    end

    assign busy      = (state_q == StAdd);
    assign done      = (state_q == StDone);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed and random operations compared against
// plain (a + b + cin) arithmetic.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         bit_out;
    logic         bit_valid;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .bit_out  (bit_out),
        .bit_valid(bit_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_sum"}, sum, 0);
        check({tag, "_cout"}, cout, 0);
        check({tag, "_bit_out"}, bit_out, 0);
        check({tag, "_bit_valid"}, bit_valid, 0);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic xc);
        logic [W:0] exp;
        exp   = ref_add(xa, xb, xc);
        a     = xa;
        b     = xb;
        cin   = xc;
        start = 1'b1;
        step();
        start = 1'b0;
        a     = ~xa;
        b     = ~xb;
        cin   = ~xc;
        check({tag, "_accept_busy"}, busy, 1);
        check({tag, "_accept_sum_clr"}, sum, 0);
        for (int i = 0; i < int'(W); i++) begin
            step();
            check({tag, "_bit_valid"}, bit_valid, 1);
            check({tag, "_bit_out"}, bit_out, exp[i]);
            if (i < int'(W) - 1) begin
                check({tag, "_busy_mid"}, busy, 1);
                check({tag, "_done_mid"}, done, 0);
            end else begin
                check({tag, "_busy_end"}, busy, 0);
                check({tag, "_done"}, done, 1);
                check({tag, "_sum"}, sum, exp[W-1:0]);
                check({tag, "_cout"}, cout, exp[W]);
            end
        end
        step();
        check({tag, "_done_drop"}, done, 0);
        check({tag, "_bv_drop"}, bit_valid, 0);
        check({tag, "_sum_hold"}, sum, exp[W-1:0]);
    endtask

    initial begin
        logic [W-1:0] ea, eb;
        logic         ec;
        logic [W:0]   exp;
        int           last_done;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        step();
        step();
        check_idle_outputs("reset");
        rst = 1'b0;
        step();
        check_idle_outputs("post_reset");

        run_op("add_5_3", 8'h05, 8'h03, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0);
        run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1);
        run_op("sub_3_5", 8'h03, 8'hFA, 1'b1);
        run_op("sub_5_3", 8'h05, 8'hFC, 1'b1);
        for (int k = 0; k < 8; k++) begin
            run_op("rand", 8'($urandom()), 8'($urandom()), 1'($urandom()));
        end

        // Start held high with operands changing every cycle: only accepted values count.
        ea        = 8'($urandom());
        eb        = 8'($urandom());
        ec        = 1'($urandom());
        a         = ea;
        b         = eb;
        cin       = ec;
        start     = 1'b1;
        last_done = -1;
        for (int k = 0; k < 3; k++) begin
            exp = ref_add(ea, eb, ec);
            step();
            check("b2b_accept_busy", busy, 1);
            check("b2b_accept_sum_clr", sum, 0);
            a   = 8'($urandom());
            b   = 8'($urandom());
            cin = 1'($urandom());
            for (int i = 1; i <= int'(W); i++) begin
                step();
                if (i < int'(W)) begin
                    check("b2b_done_mid", done, 0);
                end else begin
                    check("b2b_done", done, 1);
                    check("b2b_sum", sum, exp[W-1:0]);
                    check("b2b_cout", cout, exp[W]);
                    if (last_done >= 0) check("b2b_period", cyc - last_done, W + 1);
                    last_done = cyc;
                end
                a   = 8'($urandom());
                b   = 8'($urandom());
                cin = 1'($urandom());
                if (i == int'(W)) begin
                    ea = a;
                    eb = b;
                    ec = cin;
                end
            end
        end
        start = 1'b0;
        step();
        check("b2b_end_busy", busy, 0);
        check("b2b_end_done", done, 0);

        // Reset after the 4th bit edge aborts the operation.
        a     = 8'h5A;
        b     = 8'h33;
        cin   = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("abort_busy_before", busy, 1);
        rst = 1'b1;
        step();
        check_idle_outputs("abort");
        rst = 1'b0;
        for (int i = 0; i < int'(W) + 2; i++) begin
            step();
            check("abort_no_done", done, 0);
        end
        run_op("after_abort", 8'h10, 8'h20, 1'b0);

        // Reset wins over a simultaneous start in idle.
        rst   = 1'b1;
        start = 1'b1;
        step();
        check_idle_outputs("rst_start");
        rst   = 1'b0;
        start = 1'b0;
        step();
        check("rst_start_stay_idle", busy, 0);

        // Result holds through a long idle period.
        run_op("hold", 8'hC3, 8'h4E, 1'b1);
        exp = ref_add(8'hC3, 8'h4E, 1'b1);
        a   = 8'h00;
        b   = 8'h00;
        for (int i = 0; i < 20; i++) begin
            step();
            check("hold_sum", sum, exp[W-1:0]);
            check("hold_cout", cout, exp[W]);
            check("hold_busy", busy, 0);
            check("hold_bv", bit_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder: captures two WIDTH-bit operands and a carry-in on a start request, then adds them LSB-first over WIDTH clock cycles through a single full-adder cell and a carry flip-flop. It streams each sum bit out as it is produced and presents the full parallel sum and carry-out with a one-cycle done pulse. It is the adding counterpart to the team's subtractor cells. Subtraction a−b is available as a + ~b with cin=1, and then borrow = ~cout.

## Interface
- WIDTH, 8, operand/sum width in bits; legal range ≥ 2.

- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only on an edge where busy=0.
- a  input  WIDTH  operand A; sampled only on an accepted start.
- b  input  WIDTH  operand B; sampled only on an accepted start.
- cin  input  1  carry-in; sampled only on an accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; sum and cout are final in that cycle.
- sum  output  WIDTH  parallel result; holds until the next accepted start.
- cout  output  1  final carry-out; holds with sum.
- bit_out  output  1  most recently computed sum bit.
- bit_valid  output  1  bit_out carries a new sum bit this cycle.

## Operation
- FSM states and meaning:
  - IDLE: waiting for start.
  - ADD: processing bits.
  - DONE: one-cycle completion state.
- Transitions:
  - IDLE→ADD on start.
  - ADD→ADD while bit index < WIDTH−1.
  - ADD→DONE on the edge that processes bit WIDTH−1.
  - DONE→ADD on start, otherwise DONE→IDLE.
- Accepted start, on the edge where busy=0 and start=1:
  - a→shift register A, b→shift register B, cin→carry register.
  - Bit index←0.
  - sum and cout cleared to 0.
- Each ADD edge:
  - s = A[0]^B[0]^c; carry c ← majority(A[0],B[0],c).
  - A and B shift right by one.
  - sum shifts right with s inserted at the MSB.
  - bit_out←s, bit_valid←1, index increments.
- Entering DONE: cout←final carry; sum now holds bits [WIDTH−1:0] in natural order.
- Arithmetic is modulo 2^WIDTH. The carry out of the MSB goes to cout only; no overflow flag.
- start while busy=1 is ignored; a, b and cin are not re-sampled.
- busy = (state==ADD), driven from the registered state.
- done = (state==DONE).

## Timing
- Reset: state IDLE; busy=0, done=0, sum=0, cout=0, bit_out=0, bit_valid=0.
- Start sampled on edge E0:
  - busy=1 after E0.
  - Edges E1..E_WIDTH each process one bit, LSB first.
  - After E_WIDTH: state DONE, busy=0, done=1, sum/cout final.
  - After E_WIDTH+1: done=0.
- Latency: done asserts WIDTH cycles after the accepting edge.
- bit_valid is high for exactly WIDTH consecutive cycles, after E1..E_WIDTH. Its last cycle coincides with done.
- Back-to-back: start=1 during the done cycle is accepted on E_WIDTH+1 (sum clears). This gives one operation per WIDTH+1 cycles.
- Output stability: sum and cout hold their values through IDLE indefinitely. They change only on accept (clear) or while in ADD.
- Reset mid-operation: rst on any edge aborts the operation. All outputs return to their reset values, no done is produced, and a simultaneous start is ignored.
- rst and start high together in IDLE: reset wins.

## Test plan
- WIDTH=8, a=0x05, b=0x03, cin=0, start one cycle → busy 8 cycles; bit_out sequence LSB-first 0,0,0,1,0,0,0,0; done 8 cycles after accept; sum=0x08, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Subtract 0x03−0x05: a=0x03, b=0xFA, cin=1 → sum=0xFE, cout=0 (borrow=1). Subtract 0x05−0x03: a=0x05, b=0xFC, cin=1 → sum=0x02, cout=1.
- Hold start high and change a/b every cycle during busy → result equals the first captured operands only; the next accept occurs in the done cycle; done pulses every 9 cycles.
- Assert rst after the 4th ADD edge → all outputs 0 on the next cycle, no done; a fresh start then completes normally: 0x10+0x20 → 0x30.
- After done, hold start low for 20 cycles → sum and cout remain unchanged, busy=0, bit_valid=0.
